// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared FIFO pointer helpers: pointer width derivation and Gray/binary conversion.
package fifo_pkg;

  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Binary bit k is the XOR of all Gray bits at or above k.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int unsigned i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
module ptr_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO: read pointer, empty/almost-empty flags,
// read-valid strobe and sticky underflow, with the write pointer synchronized locally.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 3,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned AEMPTY_THRESH = 2,
  localparam int unsigned PTR_W        = ptr_width(ADDR_WIDTH)
) (
  input  logic                  R_CLK,
  input  logic                  R_RST_N,
  input  logic                  R_INC_EN,
  input  logic [PTR_W-1:0]      gray_W_ptr,
  output logic [PTR_W-1:0]      gray_R_ptr,
  output logic [ADDR_WIDTH-1:0] R_addr,
  output logic                  R_EMPTY,
  output logic                  R_AEMPTY,
  output logic                  R_VALID,
  output logic                  R_UNDERFLOW
);

  logic [PTR_W-1:0] syn_gray_W_ptr;
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rbin_next;
  logic [PTR_W-1:0] rgray_next;
  logic [PTR_W-1:0] wbin_s;
  logic [PTR_W-1:0] fill_next;
  logic             accept;
  logic             empty_next;
  logic             aempty_next;

  ptr_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk   (R_CLK),
    .rst_n (R_RST_N),
    .d     (gray_W_ptr),
    .q     (syn_gray_W_ptr)
  );

  // Both flags look at the post-read pointer so a final read raises them on the same edge.
  always_comb begin
    accept      = R_INC_EN & ~R_EMPTY;
    rbin_next   = rbin + {{(PTR_W-1){1'b0}}, accept};
    rgray_next  = PTR_W'(bin2gray(32'(rbin_next)));
    wbin_s      = PTR_W'(gray2bin(32'(syn_gray_W_ptr)));
    fill_next   = wbin_s - rbin_next;
    empty_next  = (rgray_next == syn_gray_W_ptr);
    aempty_next = (32'(fill_next) <= AEMPTY_THRESH);
  end

  always_ff @(posedge R_CLK) begin
    if (!R_RST_N) begin
      rbin        <= '0;
      gray_R_ptr  <= '0;
      R_EMPTY     <= 1'b1;
      R_AEMPTY    <= 1'b1;
      R_VALID     <= 1'b0;
      R_UNDERFLOW <= 1'b0;
    end else begin
      rbin        <= rbin_next;
      gray_R_ptr  <= rgray_next;
      R_EMPTY     <= empty_next;
      R_AEMPTY    <= aempty_next;
      R_VALID     <= accept;
      if (R_INC_EN & R_EMPTY) begin
        R_UNDERFLOW <= 1'b1;
      end
    end
  end

  assign R_addr = rbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: a count-based FIFO model predicts every cycle's outputs.
module tb_fifo_rd_ctrl;

  localparam int unsigned AW    = 3;
  localparam int unsigned PW    = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned MODP  = 16;
  localparam int unsigned THR   = 2;

  logic          R_CLK = 1'b0;
  logic          R_RST_N = 1'b0;
  logic          R_INC_EN = 1'b0;
  logic [PW-1:0] gray_W_ptr = '0;
  logic [PW-1:0] gray_R_ptr;
  logic [AW-1:0] R_addr;
  logic          R_EMPTY, R_AEMPTY, R_VALID, R_UNDERFLOW;

  fifo_rd_ctrl #(
    .ADDR_WIDTH    (AW),
    .SYNC_STAGES   (2),
    .AEMPTY_THRESH (THR)
  ) dut (
    .R_CLK       (R_CLK),
    .R_RST_N     (R_RST_N),
    .R_INC_EN    (R_INC_EN),
    .gray_W_ptr  (gray_W_ptr),
    .gray_R_ptr  (gray_R_ptr),
    .R_addr      (R_addr),
    .R_EMPTY     (R_EMPTY),
    .R_AEMPTY    (R_AEMPTY),
    .R_VALID     (R_VALID),
    .R_UNDERFLOW (R_UNDERFLOW)
  );

  always #5 R_CLK = ~R_CLK;

  typedef struct packed {
    logic [PW-1:0] g;
    logic [AW-1:0] a;
    logic          e;
    logic          ae;
    logic          v;
    logic          u;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Model state: unwrapped read count, write counts seen by the read domain in arrival order.
  int unsigned m_reads = 0;
  int unsigned m_wc    = 0;
  int unsigned hist[$] = '{0, 0};
  bit          m_empty = 1'b1;
  bit          m_aempty = 1'b1;
  bit          m_valid = 1'b0;
  bit          m_uf    = 1'b0;

  function automatic logic [PW-1:0] gray_of(input int unsigned n);
    int unsigned m;
    m = n % MODP;
    return PW'(m ^ (m >> 1));
  endfunction

  task automatic step(input bit rst, input bit inc, input int unsigned wc);
    int unsigned syn, fill;
    bit acc;
    obs_t e;
    @(negedge R_CLK);
    R_RST_N    = ~rst;
    R_INC_EN   = inc;
    gray_W_ptr = gray_of(wc);
    if (rst) begin
      m_reads = 0; m_empty = 1; m_aempty = 1; m_valid = 0; m_uf = 0;
      hist = '{0, 0};
    end else begin
      syn = hist.pop_front();
      hist.push_back(wc % MODP);
      acc = inc && !m_empty;
      if (inc && m_empty) m_uf = 1;
      m_reads  = m_reads + (acc ? 1 : 0);
      m_empty  = ((m_reads % MODP) == syn);
      fill     = (syn + MODP - (m_reads % MODP)) % MODP;
      m_aempty = (fill <= THR);
      m_valid  = acc;
    end
    e.g  = gray_of(m_reads);
    e.a  = AW'(m_reads % DEPTH);
    e.e  = m_empty;
    e.ae = m_aempty;
    e.v  = m_valid;
    e.u  = m_uf;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    obs_t e, o;
    forever begin
      @(posedge R_CLK);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = '{gray_R_ptr, R_addr, R_EMPTY, R_AEMPTY, R_VALID, R_UNDERFLOW};
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: got gray_R=%b addr=%0d empty=%b aempty=%b valid=%b uf=%b, expected gray_R=%b addr=%0d empty=%b aempty=%b valid=%b uf=%b",
                   cyc, o.g, o.a, o.e, o.ae, o.v, o.u, e.g, e.a, e.e, e.ae, e.v, e.u);
        end
      end
    end
  end

  initial begin : stimulus
    bit rst, inc;
    // Reset with write pointer at zero
    step(1, 0, 0);
    step(1, 0, 0);
    // Three entries arrive; flags clear after the synchronizer latency
    m_wc = 3;
    repeat (4) step(0, 0, m_wc);
    // Drain three, then attempt reads while empty
    repeat (3) step(0, 1, m_wc);
    repeat (3) step(0, 1, m_wc);
    repeat (3) step(0, 0, m_wc);
    // Stream through the pointer wrap to 16
    for (int i = 0; i < 40; i++) begin
      if (m_wc < 16 && (m_wc - m_reads) < DEPTH) m_wc++;
      step(0, 1, m_wc);
    end
    repeat (3) step(0, 0, m_wc);
    // Refill, then reset while a read is requested
    m_wc = 19;
    repeat (4) step(0, 0, m_wc);
    m_wc = 0;
    step(1, 1, m_wc);
    repeat (3) step(0, 0, m_wc);
    // Randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      inc = ($urandom_range(0, 1) == 1);
      if (rst) m_wc = 0;
      else if (($urandom_range(0, 2) != 0) && (m_wc - m_reads) < DEPTH) m_wc++;
      step(rst, inc, m_wc);
    end
    repeat (6) step(0, 0, m_wc);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge R_CLK);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3: FIFO memory address width; pointer width PTR_W = ADDR_WIDTH+1.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flop stages for the write-pointer synchronizer; legal values 2..4.
REQ-003 SHALL have parameter AEMPTY_THRESH, default 2: almost-empty fill-level threshold.
REQ-004 SHALL have port R_CLK, input, 1 bit: read-domain clock.
REQ-005 SHALL have port R_RST_N, input, 1 bit: read-domain reset; one clock, reset synchronous and active-low.
REQ-006 SHALL have port R_INC_EN, input, 1 bit: read request.
REQ-007 SHALL have port gray_W_ptr, input, PTR_W bits: Gray write pointer, asynchronous to R_CLK.
REQ-008 SHALL have port gray_R_ptr, output, PTR_W bits: registered Gray read pointer, sent to the write domain.
REQ-009 SHALL have port R_addr, output, ADDR_WIDTH bits: memory read address.
REQ-010 SHALL have port R_EMPTY, output, 1 bit: FIFO empty flag.
REQ-011 SHALL have port R_AEMPTY, output, 1 bit: almost-empty flag.
REQ-012 SHALL have port R_VALID, output, 1 bit: read data at the memory port is valid.
REQ-013 SHALL have port R_UNDERFLOW, output, 1 bit: sticky underflow error.

Function
REQ-014 SHALL pass gray_W_ptr through SYNC_STAGES flops to produce syn_gray_W_ptr; no other logic SHALL touch gray_W_ptr before the first flop.
REQ-015 SHALL accept a read when accept = R_INC_EN & ~R_EMPTY.
REQ-016 SHALL keep a binary pointer rbin (PTR_W bits) with rbin_next = rbin + accept, wrapping modulo 2^PTR_W so the MSB toggles every pass.
REQ-017 SHALL compute rgray_next = (rbin_next >> 1) ^ rbin_next and register it into gray_R_ptr; gray_R_ptr SHALL change by at most one bit per cycle.
REQ-018 SHALL drive R_addr from rbin[ADDR_WIDTH-1:0].
REQ-019 SHALL register R_EMPTY = (rgray_next == syn_gray_W_ptr), so a read of the last entry asserts R_EMPTY on the same edge that advances the pointer.
REQ-020 SHALL convert syn_gray_W_ptr to binary wbin_s and register R_AEMPTY = ((wbin_s - rbin_next) mod 2^PTR_W) <= AEMPTY_THRESH.
REQ-021 SHALL register R_VALID = accept, giving one cycle of latency from the accepting edge.
REQ-022 SHALL set R_UNDERFLOW on any edge where R_INC_EN & R_EMPTY; only reset SHALL clear it.
REQ-023 On an underflow attempt, SHALL leave rbin, gray_R_ptr and R_addr unchanged and drive R_VALID=0 on the next cycle.
REQ-024 R_EMPTY SHALL be pessimistic: deassertion occurs SYNC_STAGES+1 R_CLK edges after gray_W_ptr becomes stable.
REQ-025 If a read and a synchronized write-pointer change occur in the same cycle, SHALL evaluate both flags from rbin_next and the current syn_gray_W_ptr.

Reset
REQ-026 When R_RST_N=0 at a rising R_CLK edge, SHALL set: rbin=0, gray_R_ptr=0, R_addr=0, R_EMPTY=1, R_AEMPTY=1, R_VALID=0, R_UNDERFLOW=0, all synchronizer flops=0.
REQ-027 Reset asserted mid-operation SHALL take priority over any read on that edge.

Structure
REQ-028 SHALL take bin2gray and gray2bin functions and the PTR_W derivation from a shared package, fifo_pkg.
REQ-029 SHALL implement the synchronizer as sub-module ptr_sync, parameterized by width and stage count.

Verification (ADDR_WIDTH=3, SYNC_STAGES=2, AEMPTY_THRESH=2)
REQ-030 Reset: hold R_RST_N=0 for 2 edges with gray_W_ptr=0 -> R_EMPTY=1, R_AEMPTY=1, R_VALID=0, R_UNDERFLOW=0, gray_R_ptr=0000, R_addr=0.
REQ-031 Fill arrival: drive gray_W_ptr=0010 (binary 3) and hold -> R_EMPTY=0 and R_AEMPTY=0 exactly 3 edges later.
REQ-032 Drain: then hold R_INC_EN=1 for 3 cycles -> R_addr steps 0,1,2,3; R_VALID=1 for 3 cycles, lagging each accept by one cycle; R_AEMPTY=1 after the first read; R_EMPTY=1 after the third read.
REQ-033 Underflow: R_INC_EN=1 while R_EMPTY=1 -> R_addr holds at 3, R_VALID=0, R_UNDERFLOW=1 and stays 1 after R_INC_EN drops.
REQ-034 Wrap: step gray_W_ptr and reads through 16 entries -> gray_R_ptr goes 1000 then 0000; R_EMPTY=1 when both pointers equal 0000.
REQ-035 Mid-operation reset: with R_EMPTY=0 and R_INC_EN=1, pull R_RST_N=0 for 1 edge -> all outputs match the REQ-026 values on that edge.
